lb_uart_reg_slave: RTL and testbench
====================================

// Module: lb_uart_reg_slave
// PURPOSE
//  Parametrised local-bus register slave on a UART link (8N1, LSB first).
//  Decodes host read/write frames on rx into a bank of N_RW read/write registers and N_RO read-only status inputs.
//  Returns read data and write acks on tx; flags checksum errors; asserts identify once a valid frame is seen.
//  Sits between the host UART pins and the datapath configuration/status registers.
// PARAMETERS
//  DIV      434     lb_clk cycles per UART bit (50 MHz / 115200)
//  N_RW     16      number of RW registers, 1..128, addr 0x00..N_RW-1
//  N_RO     8       number of RO inputs, 1..128, addr 0x80..0x80+N_RO-1
//  RW_RST   0       N_RW*32-bit reset image; reg k = RW_RST[32k+:32]
//  TO_BITS  32      inter-byte timeout in bit times, mid-frame only
// PORTS
//  lb_clk          in   1         single clock
//  lb_reset_n      in   1         asynchronous active-low reset
//  rx              in   1         UART in, asynchronous, idle high
//  tx              out  1         UART out, idle high
//  lb_crc_error_n  out  1         low = last complete frame failed checksum
//  ubus_identify   out  1         high after first valid frame; sticky
//  ro_in           in   N_RO*32   status inputs, sampled at EXEC
//  rw_out          out  N_RW*32   RW register contents, registered
//  wr_strobe       out  N_RW      (LB_WR_STROBE_EN only) 1-cycle write pulse per reg
// BEHAVIOUR
//  Reset: tx=1, lb_crc_error_n=1, ubus_identify=0, rw_out=RW_RST, wr_strobe=0, FSM=IDLE, byte engines idle.
//  RX: 2-flop sync. Start = falling edge, confirmed low at DIV/2; data sampled mid-bit.
//    Stop bit 0 = framing error: byte dropped, parser -> IDLE.
//  Request: A5, cmd, addr, [d3 d2 d1 d0 if cmd=01], chk; chk = XOR of all bytes after A5.
//  cmd 01 = write, 02 = read; other cmd -> IDLE silently.
//  FSM: IDLE(wait A5; other bytes ignored) -> CMD -> ADDR -> DATA(x4, write only) -> CHK -> EXEC -> RESP -> IDLE.
//  CHK mismatch: lb_crc_error_n=0, no write, no response, -> IDLE.
//  Good frame: lb_crc_error_n=1, ubus_identify=1.
//  EXEC (one cycle after chk stop sample):
//    write to addr<N_RW updates rw_out next edge; writes elsewhere ignored but acked.
//    read latches rw_out[addr], ro_in[addr-0x80], or 0 for unmapped.
//  Response: 5A, cmd, addr, [d3..d0 if read], chk (same XOR rule).
//    First tx start bit begins within 2 cycles of EXEC; bytes back-to-back, 1 stop bit.
//  rx bytes arriving during RESP are discarded.
//  Timeout: no byte within TO_BITS*DIV cycles while not IDLE/RESP -> IDLE, no flag change.
//  Reset mid-frame or mid-response: all state to reset values immediately; tx forced 1.
// CONFIGURATION
//  LB_WR_STROBE_EN defined: wr_strobe port exists; wr_strobe[k]=1 for exactly the cycle rw_out reg k updates.
//    Pulse also fires when the written value equals the old value.
//  Not defined: no wr_strobe port/logic; everything else identical.
// STRUCTURE
//  lb_uart_pkg: HDR_REQ=8'hA5, HDR_RSP=8'h5A, CMD_WR=8'h01, CMD_RD=8'h02, RO_BASE=8'h80, parser state encodings.
//  Sub-module lb_uart_phy: rx sync/deserialiser (byte, valid, ferr) + tx serialiser (byte, start, busy); params DIV.
//  Top: parser FSM, register bank, response sequencer, timeout counter.
// TESTING
//  1 Write: A5 01 03 12 34 56 78 0A -> rw_out reg3=32'h12345678 at EXEC; tx: 5A 01 03 02; ubus_identify=1.
//  2 Read RO: ro_in[1]=CAFEF00D, send A5 02 81 83 -> tx: 5A 02 81 CA FE F0 0D 4A.
//  3 Bad chk: A5 01 03 12 34 56 78 0B -> reg3 unchanged, lb_crc_error_n=0, tx idle; then good frame -> lb_crc_error_n=1.
//  4 Timeout: A5 01 03 12, idle 40 bit times, then A5 02 03 01 -> read resp, reg3 unchanged.
//  5 Framing error: corrupt stop bit of addr byte -> frame dropped, no response.
//    Reset mid-RESP -> tx=1, rw_out=RW_RST.
//  6 LB_WR_STROBE_EN: scenario 1 -> wr_strobe=16'h0008 for one cycle.
//    Write to 0x90 -> ack, no strobe, rw_out unchanged.

Source files
------------

// File: rtl/lb_uart_pkg.sv
// Shared constants, state encodings and response helpers for the UART local-bus register slave.
// Optional feature in the top level: LB_WR_STROBE_EN adds per-register write strobes.
package lb_uart_pkg;

    localparam logic [7:0] HDR_REQ = 8'hA5;
    localparam logic [7:0] HDR_RSP = 8'h5A;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RO_BASE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_RESP
    } lb_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    // Byte idx of a response frame; reads carry four data bytes before the checksum.
    function automatic logic [7:0] rsp_byte(input logic [3:0]  idx,
                                            input logic        is_rd,
                                            input logic [7:0]  cmd,
                                            input logic [7:0]  addr,
                                            input logic [31:0] data);
        logic [7:0] chk;
        logic [7:0] b;
        chk = cmd ^ addr ^ (is_rd ? xor_bytes(data) : 8'h00);
        case (idx)
            4'd0:    b = HDR_RSP;
            4'd1:    b = cmd;
            4'd2:    b = addr;
            4'd3:    b = is_rd ? data[31:24] : chk;
            4'd4:    b = data[23:16];
            4'd5:    b = data[15:8];
            4'd6:    b = data[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lb_uart_phy.sv
// UART 8N1 byte engines: synchronised receiver with framing check and transmit serialiser.
module lb_uart_phy
    import lb_uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       lb_clk,
    input  logic       lb_reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    logic            rx_m_q, rx_s_q, rx_p_q;
    rx_state_e       rx_st_q, rx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_nb_q, tx_nb_d;
    logic [8:0]      tx_sh_q, tx_sh_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_p_q && !rx_s_q) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == FULL) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (rx_cnt_q == FULL) begin
                rx_cnt_d   = '0;
                rx_st_d    = RX_IDLE;
                rx_valid_d = rx_s_q;
                rx_ferr_d  = !rx_s_q;
            end
        endcase
    end

    // Shift register holds data bits then the stop bit; tx_q is the registered line.
    always_comb begin
        tx_d     = tx_q;
        busy_d   = busy_q;
        tx_cnt_d = tx_cnt_q + 1'b1;
        tx_nb_d  = tx_nb_q;
        tx_sh_d  = tx_sh_q;
        if (!busy_q) begin
            tx_cnt_d = '0;
            if (tx_start) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                tx_sh_d = {1'b1, tx_byte};
                tx_nb_d = '0;
            end
        end else if (tx_cnt_q == FULL) begin
            tx_cnt_d = '0;
            if (tx_nb_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                tx_d    = tx_sh_q[0];
                tx_sh_d = {1'b1, tx_sh_q[8:1]};
                tx_nb_d = tx_nb_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge lb_clk or negedge lb_reset_n) begin
        if (!lb_reset_n) begin
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_cnt_q   <= '0;
            tx_nb_q    <= '0;
            tx_sh_q    <= '1;
        end else begin
            rx_m_q     <= rx;
            rx_s_q     <= rx_m_q;
            rx_p_q     <= rx_s_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_nb_q    <= tx_nb_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    assign rx_byte  = rx_sh_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign tx_busy  = busy_q;
    assign tx       = tx_q;

endmodule

// File: rtl/lb_uart_reg_slave.sv
// Local-bus register slave on a UART link: frame parser, RW/RO register bank, response sequencer.
// Define LB_WR_STROBE_EN to add the wr_strobe output (one-cycle pulse per register write).
module lb_uart_reg_slave
    import lb_uart_pkg::*;
#(
    parameter int                 DIV     = 434,
    parameter int                 N_RW    = 16,
    parameter int                 N_RO    = 8,
    parameter logic [N_RW*32-1:0] RW_RST  = '0,
    parameter int                 TO_BITS = 32
) (
    input  logic                lb_clk,
    input  logic                lb_reset_n,
    input  logic                rx,
    output logic                tx,
    output logic                lb_crc_error_n,
    output logic                ubus_identify,
    input  logic [N_RO*32-1:0]  ro_in,
    output logic [N_RW*32-1:0]  rw_out
`ifdef LB_WR_STROBE_EN
    ,
    output logic [N_RW-1:0]     wr_strobe
`endif
);

    localparam int TO_CYC = TO_BITS * DIV;

    logic [7:0]  rx_byte, tx_byte;
    logic        rx_valid, rx_ferr, tx_start, tx_busy;

    lb_state_e   state_q, state_d;
    logic [7:0]  cmd_q, cmd_d, addr_q, addr_d, chk_q, chk_d;
    logic [31:0] data_q, data_d, rsp_data_q, rsp_data_d, to_cnt_q, to_cnt_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [3:0]  rsp_idx_q, rsp_idx_d, rsp_len;
    logic        crc_n_q, crc_n_d, ident_q, ident_d, is_rd, mid_frame;
    logic [31:0] rw_q [N_RW];
    logic [31:0] rw_d [N_RW];
    logic [N_RW-1:0] wr_hit;

    lb_uart_phy #(.DIV(DIV)) u_phy (
        .lb_clk    (lb_clk),
        .lb_reset_n(lb_reset_n),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_ferr   (rx_ferr),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx        (tx)
    );

    assign is_rd     = (cmd_q == CMD_RD);
    assign rsp_len   = is_rd ? 4'd8 : 4'd4;
    assign tx_byte   = rsp_byte(rsp_idx_q, is_rd, cmd_q, addr_q, rsp_data_q);
    assign mid_frame = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                       (state_q == ST_DATA) || (state_q == ST_CHK);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        chk_d      = chk_q;
        data_d     = data_q;
        dcnt_d     = dcnt_q;
        rsp_idx_d  = rsp_idx_q;
        rsp_data_d = rsp_data_q;
        crc_n_d    = crc_n_q;
        ident_d    = ident_q;
        rw_d       = rw_q;
        wr_hit     = '0;
        tx_start   = 1'b0;
        to_cnt_d   = (mid_frame && !rx_valid) ? to_cnt_q + 32'd1 : 32'd0;

        case (state_q)
            ST_IDLE: if (rx_valid && rx_byte == HDR_REQ) begin
                chk_d   = '0;
                state_d = ST_CMD;
            end
            ST_CMD: if (rx_valid) begin
                cmd_d   = rx_byte;
                chk_d   = chk_q ^ rx_byte;
                state_d = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ST_ADDR : ST_IDLE;
            end
            ST_ADDR: if (rx_valid) begin
                addr_d  = rx_byte;
                chk_d   = chk_q ^ rx_byte;
                dcnt_d  = '0;
                state_d = (cmd_q == CMD_WR) ? ST_DATA : ST_CHK;
            end
            ST_DATA: if (rx_valid) begin
                data_d = {data_q[23:0], rx_byte};
                chk_d  = chk_q ^ rx_byte;
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd3) state_d = ST_CHK;
            end
            ST_CHK: if (rx_valid) begin
                crc_n_d = (rx_byte == chk_q);
                if (rx_byte == chk_q) begin
                    ident_d = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d = '0;
                if (cmd_q == CMD_WR) begin
                    for (int k = 0; k < N_RW; k++) begin
                        if (addr_q == 8'(k)) begin
                            wr_hit[k] = 1'b1;
                            rw_d[k]   = data_q;
                        end
                    end
                end else begin
                    for (int k = 0; k < N_RW; k++)
                        if (addr_q == 8'(k)) rsp_data_d = rw_q[k];
                    for (int k = 0; k < N_RO; k++)
                        if (addr_q == 8'(RO_BASE + k)) rsp_data_d = ro_in[32*k +: 32];
                end
                rsp_idx_d = '0;
                state_d   = ST_RESP;
            end
            default: if (!tx_busy) begin
                // Incoming rx bytes are ignored until the last response byte has left.
                if (rsp_idx_q == rsp_len) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_start  = 1'b1;
                    rsp_idx_d = rsp_idx_q + 4'd1;
                end
            end
        endcase

        if (mid_frame && (rx_ferr || (!rx_valid && to_cnt_q == 32'(TO_CYC - 1))))
            state_d = ST_IDLE;
    end

    always_ff @(posedge lb_clk or negedge lb_reset_n) begin
        if (!lb_reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            chk_q      <= '0;
            data_q     <= '0;
            dcnt_q     <= '0;
            to_cnt_q   <= '0;
            rsp_idx_q  <= '0;
            rsp_data_q <= '0;
            crc_n_q    <= 1'b1;
            ident_q    <= 1'b0;
            // NOTE: the register bank is architectural state with a defined reset image, so it is reset here.
            for (int k = 0; k < N_RW; k++) rw_q[k] <= RW_RST[32*k +: 32];
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            chk_q      <= chk_d;
            data_q     <= data_d;
            dcnt_q     <= dcnt_d;
            to_cnt_q   <= to_cnt_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_data_q <= rsp_data_d;
            crc_n_q    <= crc_n_d;
            ident_q    <= ident_d;
            rw_q       <= rw_d;
        end
    end

`ifdef LB_WR_STROBE_EN
    logic [N_RW-1:0] strobe_q;

    always_ff @(posedge lb_clk or negedge lb_reset_n) begin
        if (!lb_reset_n) strobe_q <= '0;
        else             strobe_q <= wr_hit;
    end

    assign wr_strobe = strobe_q;
`endif

    for (genvar k = 0; k < N_RW; k++) begin : g_rw_out
        assign rw_out[32*k +: 32] = rw_q[k];
    end

    assign lb_crc_error_n = crc_n_q;
    assign ubus_identify  = ident_q;

endmodule

// File: tb/tb_lb_uart_reg_slave.sv
// Directed bench for lb_uart_reg_slave: UART host driver, response monitor, per-scenario checks.
module tb_lb_uart_reg_slave;
    import lb_uart_pkg::*;

    localparam int DIV     = 16;
    localparam int N_RW    = 16;
    localparam int N_RO    = 8;
    localparam int TO_BITS = 32;

    function automatic logic [N_RW*32-1:0] mk_rst();
        logic [N_RW*32-1:0] img;
        for (int k = 0; k < N_RW; k++) img[32*k +: 32] = 32'h1000_0000 | 32'(k);
        return img;
    endfunction

    localparam logic [N_RW*32-1:0] RST_IMG = mk_rst();

    typedef logic [7:0] bq_t[$];

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rx;
    logic                tx;
    logic                crc_n;
    logic                ident;
    logic [N_RO*32-1:0]  ro_in;
    logic [N_RW*32-1:0]  rw_out;
`ifdef LB_WR_STROBE_EN
    logic [N_RW-1:0]     wr_strobe;
`endif

    bq_t                 rsp_q;
    bq_t                 frm;
    bq_t                 exp;
    logic [N_RW*32-1:0]  exp_rw;
    int                  total = 0;
    int                  bad = 0;

    always #5 clk = ~clk;

    lb_uart_reg_slave #(
        .DIV(DIV), .N_RW(N_RW), .N_RO(N_RO), .RW_RST(RST_IMG), .TO_BITS(TO_BITS)
    ) dut (
        .lb_clk        (clk),
        .lb_reset_n    (rst_n),
        .rx            (rx),
        .tx            (tx),
        .lb_crc_error_n(crc_n),
        .ubus_identify (ident),
        .ro_in         (ro_in),
        .rw_out        (rw_out)
`ifdef LB_WR_STROBE_EN
        ,
        .wr_strobe     (wr_strobe)
`endif
    );

    // Response monitor: decodes tx bytes mid-bit into rsp_q.
    initial begin : mon
        logic [7:0] mb;
        forever begin
            @(negedge tx);
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                mb[i] = tx;
            end
            repeat (DIV) @(negedge clk);
            rsp_q.push_back(mb);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send_byte(f[i], 1'b1);
    endtask

    // Waits (bounded) for n response bytes, then a little longer to expose extra bytes.
    task automatic wait_rsp(input int n);
        int cyc = 0;
        while (rsp_q.size() < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (12 * DIV) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        ro_in = '0;
        ro_in[31:0]  = 32'h1111_1111;
        ro_in[63:32] = 32'hCAFE_F00D;
        ro_in[95:64] = 32'h2222_2222;
        repeat (4) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (crc_n !== 1'b1) begin bad++; $display("FAIL reset_crc_n: got %b want 1", crc_n); end
        total++; if (ident !== 1'b0) begin bad++; $display("FAIL reset_identify: got %b want 0", ident); end
        total++; if (rw_out !== RST_IMG) begin bad++; $display("FAIL reset_rw_out: got %h want %h", rw_out, RST_IMG); end
        rst_n  = 1'b1;
        exp_rw = RST_IMG;
        repeat (4) @(negedge clk);
        rsp_q.delete();
    endtask

    task automatic test_write();
        rsp_q.delete();
        frm = '{8'hA5, 8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
        exp = '{8'h5A, 8'h01, 8'h03, 8'h02};
        send_frame(frm);
        exp_rw[3*32 +: 32] = 32'h1234_5678;
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL write_rsp_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL write_rsp[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
        total++; if (rw_out !== exp_rw) begin bad++; $display("FAIL write_rw_out: got %h want %h", rw_out, exp_rw); end
        total++; if (ident !== 1'b1) begin bad++; $display("FAIL write_identify: got %b want 1", ident); end
        total++; if (crc_n !== 1'b1) begin bad++; $display("FAIL write_crc_n: got %b want 1", crc_n); end
    endtask

    task automatic test_read_ro();
        rsp_q.delete();
        frm = '{8'hA5, 8'h02, 8'h81, 8'h83};
        exp = '{8'h5A, 8'h02, 8'h81, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h4A};
        send_frame(frm);
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL read_ro_rsp_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL read_ro_rsp[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
    endtask

    task automatic test_bad_chk();
        rsp_q.delete();
        frm = '{8'hA5, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0B};
        send_frame(frm);
        repeat (20 * DIV) @(negedge clk);
        total++; if (rsp_q.size() != 0) begin bad++; $display("FAIL badchk_no_rsp: got %0d bytes want 0", rsp_q.size()); end
        total++; if (crc_n !== 1'b0) begin bad++; $display("FAIL badchk_crc_n: got %b want 0", crc_n); end
        total++; if (rw_out !== exp_rw) begin bad++; $display("FAIL badchk_rw_out: got %h want %h", rw_out, exp_rw); end
        frm = '{8'hA5, 8'h01, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
        exp = '{8'h5A, 8'h01, 8'h05, 8'h04};
        send_frame(frm);
        exp_rw[5*32 +: 32] = 32'hDEAD_BEEF;
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL recover_rsp_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL recover_rsp[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
        total++; if (crc_n !== 1'b1) begin bad++; $display("FAIL recover_crc_n: got %b want 1", crc_n); end
        total++; if (rw_out !== exp_rw) begin bad++; $display("FAIL recover_rw_out: got %h want %h", rw_out, exp_rw); end
    endtask

    task automatic test_timeout();
        rsp_q.delete();
        frm = '{8'hA5, 8'h01, 8'h03, 8'h55};
        send_frame(frm);
        repeat (40 * DIV) @(negedge clk);
        frm = '{8'hA5, 8'h02, 8'h03, 8'h01};
        exp = '{8'h5A, 8'h02, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_frame(frm);
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL timeout_rsp_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL timeout_rsp[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
        total++; if (crc_n !== 1'b1) begin bad++; $display("FAIL timeout_crc_n: got %b want 1", crc_n); end
        total++; if (rw_out !== exp_rw) begin bad++; $display("FAIL timeout_rw_out: got %h want %h", rw_out, exp_rw); end
    endtask

    task automatic test_unmapped();
        rsp_q.delete();
        frm = '{8'hA5, 8'h02, 8'h40, 8'h42};
        exp = '{8'h5A, 8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h42};
        send_frame(frm);
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL unmapped_rd_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL unmapped_rd[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
        rsp_q.delete();
        frm = '{8'hA5, 8'h01, 8'h90, 8'h11, 8'h22, 8'h33, 8'h44, 8'hD5};
        exp = '{8'h5A, 8'h01, 8'h90, 8'h91};
        send_frame(frm);
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL unmapped_wr_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL unmapped_wr[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
        total++; if (rw_out !== exp_rw) begin bad++; $display("FAIL unmapped_wr_rw_out: got %h want %h", rw_out, exp_rw); end
    endtask

    task automatic test_framing();
        rsp_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        send_byte(8'h01, 1'b1);
        repeat (20 * DIV) @(negedge clk);
        total++; if (rsp_q.size() != 0) begin bad++; $display("FAIL ferr_no_rsp: got %0d bytes want 0", rsp_q.size()); end
        frm = '{8'hA5, 8'h02, 8'h05, 8'h07};
        exp = '{8'h5A, 8'h02, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h25};
        send_frame(frm);
        wait_rsp(exp.size());
        total++; if (rsp_q.size() != exp.size()) begin bad++; $display("FAIL ferr_recover_len: got %0d want %0d", rsp_q.size(), exp.size()); end
        else foreach (exp[i]) begin
            total++; if (rsp_q[i] !== exp[i]) begin bad++; $display("FAIL ferr_recover[%0d]: got %h want %h", i, rsp_q[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_rsp();
        int cyc = 0;
        rsp_q.delete();
        frm = '{8'hA5, 8'h02, 8'h05, 8'h07};
        send_frame(frm);
        while (tx !== 1'b0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL midrsp_start: got tx=%b want 0 (no response started)", tx); end
        repeat (3 * DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrsp_tx: got %b want 1", tx); end
        total++; if (rw_out !== RST_IMG) begin bad++; $display("FAIL midrsp_rw_out: got %h want %h", rw_out, RST_IMG); end
        total++; if (ident !== 1'b0) begin bad++; $display("FAIL midrsp_identify: got %b want 0", ident); end
        repeat (4) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrsp_tx_held: got %b want 1", tx); end
        rst_n  = 1'b1;
        exp_rw = RST_IMG;
        repeat (15 * DIV) @(negedge clk);
        rsp_q.delete();
    endtask

`ifdef LB_WR_STROBE_EN
    task automatic test_strobe();
        int n_pulse = 0;
        logic [N_RW-1:0] seen = '0;
        rsp_q.delete();
        frm = '{8'hA5, 8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
        fork
            begin send_frame(frm); wait_rsp(4); end
            repeat (3000) begin
                @(negedge clk);
                if (wr_strobe != '0) begin n_pulse++; seen = wr_strobe; end
            end
        join
        exp_rw[3*32 +: 32] = 32'h1234_5678;
        total++; if (n_pulse != 1) begin bad++; $display("FAIL strobe_cycles: got %0d want 1", n_pulse); end
        total++; if (seen !== 16'h0008) begin bad++; $display("FAIL strobe_value: got %h want 0008", seen); end
        total++; if (rw_out !== exp_rw) begin bad++; $display("FAIL strobe_rw_out: got %h want %h", rw_out, exp_rw); end
        n_pulse = 0;
        rsp_q.delete();
        frm = '{8'hA5, 8'h01, 8'h90, 8'h11, 8'h22, 8'h33, 8'h44, 8'hD5};
        fork
            begin send_frame(frm); wait_rsp(4); end
            repeat (3000) begin
                @(negedge clk);
                if (wr_strobe != '0) n_pulse++;
            end
        join
        total++; if (n_pulse != 0) begin bad++; $display("FAIL strobe_unmapped: got %0d pulses want 0", n_pulse); end
        total++; if (rsp_q.size() != 4) begin bad++; $display("FAIL strobe_unmapped_ack: got %0d bytes want 4", rsp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_ro();
        test_bad_chk();
        test_timeout();
        test_unmapped();
        test_framing();
        test_reset_mid_rsp();
`ifdef LB_WR_STROBE_EN
        test_strobe();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
